// File: rtl/dog_sprite_renderer.sv
// dog_sprite_renderer: draws four rectangular dog boxes over a flat background.
// Per-dog state is snapshotted on frame_tick so a frame never tears. Two pipeline
// stages follow: a per-dog hit test, then priority resolution and colouring.
// Optional feature macro: DOG_SPRITE_FLASH_EN (frame counter driven hide/invert
// effects controlled by power_state).
module dog_sprite_renderer #(
  parameter int         SCREEN_W = 640,
  parameter int         SCREEN_H = 480,
  parameter int         BOX_W    = 48,
  parameter int         BOX_H    = 32,
  parameter logic [5:0] BG_RGB   = 6'b000001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       pix_valid,
  input  logic [9:0] posx0,
  input  logic [9:0] posx1,
  input  logic [9:0] posx2,
  input  logic [9:0] posx3,
  input  logic [8:0] posy0,
  input  logic [8:0] posy1,
  input  logic [8:0] posy2,
  input  logic [8:0] posy3,
  input  logic [2:0] color_idx0,
  input  logic [2:0] color_idx1,
  input  logic [2:0] color_idx2,
  input  logic [2:0] color_idx3,
  input  logic [1:0] power_state0,
  input  logic [1:0] power_state1,
  input  logic [1:0] power_state2,
  input  logic [1:0] power_state3,
  output logic [5:0] rgb,
  output logic       rgb_valid
);

  // All box arithmetic is done at 11 bits so right/bottom edges never wrap.
  localparam logic [10:0] BOX_W11 = 11'(BOX_W);
  localparam logic [10:0] BOX_H11 = 11'(BOX_H);
  localparam logic [10:0] SCR_W11 = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H11 = 11'(SCREEN_H);
  localparam logic [5:0]  WHITE   = 6'b111111;

  logic [3:0][9:0] posx_in;
  logic [3:0][8:0] posy_in;
  logic [3:0][2:0] color_in;

  assign posx_in  = {posx3, posx2, posx1, posx0};
  assign posy_in  = {posy3, posy2, posy1, posy0};
  assign color_in = {color_idx3, color_idx2, color_idx1, color_idx0};

  logic [3:0][9:0] sh_posx_q, sh_posx_d;
  logic [3:0][8:0] sh_posy_q, sh_posy_d;
  logic [3:0][2:0] sh_color_q, sh_color_d;

  logic [3:0]      in_box_q, in_box_d;
  logic [3:0]      on_edge_q, on_edge_d;
  logic [3:0]      invert_q, invert_d;
  logic [3:0][2:0] cidx_q, cidx_d;
  logic            valid_q, valid_d;

  logic [5:0]      rgb_q, rgb_d;
  logic            rgb_valid_q, rgb_valid_d;

`ifdef DOG_SPRITE_FLASH_EN
  logic [3:0][1:0] power_in;
  logic [3:0][1:0] sh_power_q, sh_power_d;
  logic [4:0]      frame_cnt_q, frame_cnt_d;

  assign power_in = {power_state3, power_state2, power_state1, power_state0};
`else
  logic unused_power;

  assign unused_power = ^{power_state3, power_state2, power_state1, power_state0};
`endif

  // Fixed 7-entry palette; index 0 is never drawn so its value is irrelevant.
  function automatic logic [5:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    return 6'b110000;
      3'd2:    return 6'b001100;
      3'd3:    return 6'b000011;
      3'd4:    return 6'b111100;
      3'd5:    return 6'b110011;
      3'd6:    return 6'b001111;
      3'd7:    return 6'b101010;
      default: return 6'b000000;
    endcase
  endfunction

  logic [10:0] beam_x, beam_y;
  logic [3:0]  hit, on_border;

  assign beam_x = {1'b0, hpos};
  assign beam_y = {1'b0, vpos};

  for (genvar i = 0; i < 4; i++) begin : g_dog
    logic [10:0] left, top, right, bottom;
    assign left   = {1'b0, sh_posx_q[i]};
    assign top    = {2'b00, sh_posy_q[i]};
    assign right  = left + BOX_W11;
    assign bottom = top + BOX_H11;
    assign hit[i] = (sh_color_q[i] != 3'd0) &&
                    (beam_x >= left) && (beam_x < right) &&
                    (beam_y >= top) && (beam_y < bottom);
    assign on_border[i] = (beam_x == left) || (beam_x == right - 11'd1) ||
                          (beam_y == top) || (beam_y == bottom - 11'd1);
  end

  // Shadow capture on frame_tick and stage-1 per-dog hit/edge evaluation.
  always_comb begin
    sh_posx_d  = frame_tick ? posx_in  : sh_posx_q;
    sh_posy_d  = frame_tick ? posy_in  : sh_posy_q;
    sh_color_d = frame_tick ? color_in : sh_color_q;
    valid_d    = pix_valid && (beam_x < SCR_W11) && (beam_y < SCR_H11);
    cidx_d     = sh_color_q;
    in_box_d   = hit;
    invert_d   = 4'b0000;
`ifdef DOG_SPRITE_FLASH_EN
    sh_power_d  = frame_tick ? power_in : sh_power_q;
    frame_cnt_d = frame_tick ? frame_cnt_q + 5'd1 : frame_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if ((sh_power_q[i] == 2'd1) && frame_cnt_q[3]) begin
        in_box_d[i] = 1'b0;
      end
      invert_d[i] = (sh_power_q[i] == 2'd2);
    end
`endif
    on_edge_d = in_box_d & on_border;
  end

  // Stage 2: lowest-index visible dog wins; edges white, interiors palette colour.
  always_comb begin
    rgb_d       = 6'b000000;
    rgb_valid_d = valid_q;
    if (valid_q) begin
      rgb_d = BG_RGB;
      for (int i = 3; i >= 0; i--) begin
        if (in_box_q[i]) begin
          rgb_d = on_edge_q[i] ? WHITE : (palette(cidx_q[i]) ^ {6{invert_q[i]}});
        end
      end
    end
  end

  // State register: shadows, pipeline stages and (optionally) frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_posx_q   <= '0;
      sh_posy_q   <= '0;
      sh_color_q  <= '0;
      in_box_q    <= '0;
      on_edge_q   <= '0;
      invert_q    <= '0;
      cidx_q      <= '0;
      valid_q     <= 1'b0;
      rgb_q       <= 6'b000000;
      rgb_valid_q <= 1'b0;
`ifdef DOG_SPRITE_FLASH_EN
      sh_power_q  <= '0;
      frame_cnt_q <= 5'd0;
`endif
    end else begin
      sh_posx_q   <= sh_posx_d;
      sh_posy_q   <= sh_posy_d;
      sh_color_q  <= sh_color_d;
      in_box_q    <= in_box_d;
      on_edge_q   <= on_edge_d;
      invert_q    <= invert_d;
      cidx_q      <= cidx_d;
      valid_q     <= valid_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
`ifdef DOG_SPRITE_FLASH_EN
      sh_power_q  <= sh_power_d;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule
